instr_ram_prefetch: RTL and testbench
=====================================

INSTR_RAM_PREFETCH -- requirements
Module: instr_ram_prefetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, byte-address width of the instruction RAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, prefetch buffer entries (power of two, >=2).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 enable_i  input  1  permits issuing new RAM reads.
REQ-008 branch_i  input  1  restart fetch at branch_addr_i, flush buffered and in-flight words.
REQ-009 branch_addr_i  input  ADDR_WIDTH  byte address of restart; bits [1:0] ignored.
REQ-010 ram_en_o  output  1  RAM read strobe.
REQ-011 ram_addr_o  output  ADDR_WIDTH  RAM byte address, bits [1:0] always 0.
REQ-012 ram_we_o  output  1  constant 0.
REQ-013 ram_be_o  output  DATA_WIDTH/8  constant all ones.
REQ-014 ram_wdata_o  output  DATA_WIDTH  constant 0.
REQ-015 ram_rdata_i  input  DATA_WIDTH  RAM read data, valid the cycle after ram_en_o.
REQ-016 instr_valid_o  output  1  head entry valid.
REQ-017 instr_rdata_o  output  DATA_WIDTH  head instruction word.
REQ-018 instr_addr_o  output  ADDR_WIDTH  byte address of head word.
REQ-019 instr_ready_i  input  1  consumer pops head when valid and ready.

Function
REQ-020 SHALL implement states IDLE and RUN; IDLE->RUN on branch_i; RUN->RUN on branch_i; no other transitions except reset.
REQ-021 In IDLE ram_en_o SHALL be 0 and instr_valid_o 0.
REQ-022 ram_en_o and ram_addr_o SHALL be registered; branch_i sampled at edge t gives ram_en_o=1, ram_addr_o={branch_addr_i[ADDR_WIDTH-1:2],2'b00} in cycle t+1 if enable_i was 1 at t.
REQ-023 Read data SHALL be written to FIFO at end of the cycle following ram_en_o; first instr_valid_o after branch in cycle t+3.
REQ-024 Issue rule: in RUN, next-cycle ram_en_o=1 iff enable_i && (fifo_count + inflight - pop) < FIFO_DEPTH, pop = instr_valid_o && instr_ready_i.
REQ-025 Fetch address SHALL increment by 4 per issued read, modulo 2^ADDR_WIDTH (wrap to 0 after last word).
REQ-026 With enable_i=1 and instr_ready_i held 1, SHALL sustain one word per cycle after initial latency.
REQ-027 Each FIFO entry SHALL hold word and its address; instr_rdata_o/instr_addr_o stable while valid and not ready.
REQ-028 branch_i SHALL, same edge, empty FIFO, mark any in-flight read stale (its data dropped), and ignore a coinciding pop.
REQ-029 enable_i=0 SHALL stop new issues only; in-flight read completes, buffered words remain poppable.
REQ-030 FIFO SHALL never overflow; pop on empty SHALL be impossible (valid=0).

Reset
REQ-031 rst_i=1 at an edge SHALL set state IDLE, ram_en_o=0, ram_addr_o=0, fifo_count=0, inflight=0, instr_valid_o=0, fetch address 0.
REQ-032 Reset mid-operation SHALL discard in-flight data returning the following cycle.
REQ-033 instr_rdata_o/instr_addr_o SHALL read 0 after reset until first write.

Structure
REQ-034 State enum and word-increment constant (4) SHALL live in shared package instr_fetch_pkg.
REQ-035 Buffer SHALL be sub-module instr_prefetch_fifo (sync FIFO, push/pop/flush, count output).
REQ-036 Top-level SHALL hold FSM, issue counter, in-flight/stale flag; connects to sp_ram_wrap_instr read port.

Verification
REQ-037 Branch to 0x0100, ready=1, RAM model preloaded -> ram_en_o cycles t+1..; words from 0x0100,0x0104,... valid from t+3, one per cycle.
REQ-038 ready=0 after branch to 0x0000 -> exactly 2 reads issued, then ram_en_o=0; valid held with addr 0x0000 stable.
REQ-039 Branch to 0x7FF8 (ADDR_WIDTH=15) -> addresses 0x7FF8, 0x7FFC, 0x0000 delivered in order.
REQ-040 Branch to 0x0200 while read of 0x0040 in flight, with ready=1 same cycle -> no 0x0040 word delivered; next valid addr 0x0200.
REQ-041 enable_i dropped mid-stream -> no new ram_en_o; buffered words still popped; enable_i=1 resumes at next sequential address.
REQ-042 rst_i asserted one cycle during RUN -> all outputs at reset values next cycle; no valid until new branch_i.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction prefetch block: fetch FSM states,
// the per-read address step and a sizing helper for the buffer occupancy counter.
package instr_fetch_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    // Byte distance between consecutive instruction words.
    localparam int unsigned WORD_INCR = 4;

    // The occupancy counter must represent 0..depth inclusive.
    function automatic int fifo_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Show-ahead synchronous FIFO holding fetched words together with their byte addresses.
// Flush empties the buffer on the same edge and overrides any coinciding push or pop.
module instr_prefetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15,
    parameter int DEPTH      = 2,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = fifo_count_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] data_mem_reg [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem_reg [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic                  push_en;
    logic                  pop_en;
    logic [DEPTH-1:0]      wr_sel;

    // Push into a full buffer and pop from an empty one are both refused here,
    // so a misbehaving producer or consumer cannot corrupt the pointers.
    assign push_en = push && !flush && (count_reg != CNT_W'(DEPTH));
    assign pop_en  = pop  && !flush && (count_reg != '0);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push_en && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_reg[i] <= '0;
                addr_mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    data_mem_reg[i] <= push_data;
                    addr_mem_reg[i] <= push_addr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push_en) - CNT_W'(pop_en);
        end
    end

    assign valid     = (count_reg != '0);
    assign head_data = data_mem_reg[rd_ptr_reg];
    assign head_addr = addr_mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/instr_ram_prefetch.sv
// Instruction prefetcher: streams sequential words from a single-port RAM read port
// into a small buffer, restarting on branch and discarding stale returning data.
module instr_ram_prefetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    branch_i,
    input  logic [ADDR_WIDTH-1:0]   branch_addr_i,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
    output logic                    instr_valid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    output logic [ADDR_WIDTH-1:0]   instr_addr_o,
    input  logic                    instr_ready_i
);

    localparam int CNT_W = fifo_count_width(FIFO_DEPTH);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(WORD_INCR);

    fetch_state_t          state_reg, state_next;
    logic [ADDR_WIDTH-1:0] fetch_addr_reg, fetch_addr_next;
    logic                  ram_en_reg, ram_en_next;
    logic [ADDR_WIDTH-1:0] ram_addr_reg, ram_addr_next;
    logic                  inflight_reg, inflight_next;
    logic [ADDR_WIDTH-1:0] inflight_addr_reg, inflight_addr_next;
    logic                  stale_reg, stale_next;

    logic                  fifo_valid;
    logic [CNT_W-1:0]      fifo_count;
    logic                  push;
    logic                  pop;
    logic [SUM_W-1:0]      committed;
    logic                  room;
    logic [ADDR_WIDTH-1:0] branch_word;
    logic                  unused_addr_bits;

    assign branch_word      = {branch_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign unused_addr_bits = ^branch_addr_i[1:0];

    // Data returning this cycle belongs to the read issued last cycle; a branch
    // on that read's issue edge marks it stale so it never reaches the buffer.
    assign push = inflight_reg && !stale_reg;
    assign pop  = instr_valid_o && instr_ready_i;

    // Words that will occupy the buffer once everything already requested has
    // landed: buffered now, landing at this edge, and issued this cycle.
    assign committed = SUM_W'(fifo_count) + SUM_W'(push) + SUM_W'(ram_en_reg) - SUM_W'(pop);
    assign room      = (committed < SUM_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (branch_i) begin
            state_next = ST_RUN;
        end
    end

    always_comb begin
        ram_en_next        = 1'b0;
        ram_addr_next      = ram_addr_reg;
        fetch_addr_next    = fetch_addr_reg;
        inflight_next      = ram_en_reg;
        inflight_addr_next = ram_addr_reg;
        stale_next         = branch_i;
        if (branch_i) begin
            ram_en_next     = enable_i;
            ram_addr_next   = branch_word;
            fetch_addr_next = enable_i ? (branch_word + ADDR_STEP) : branch_word;
        end else if ((state_reg == ST_RUN) && enable_i && room) begin
            ram_en_next     = 1'b1;
            ram_addr_next   = fetch_addr_reg;
            fetch_addr_next = fetch_addr_reg + ADDR_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            fetch_addr_reg    <= '0;
            ram_en_reg        <= 1'b0;
            ram_addr_reg      <= '0;
            inflight_reg      <= 1'b0;
            inflight_addr_reg <= '0;
            stale_reg         <= 1'b0;
        end else begin
            fetch_addr_reg    <= fetch_addr_next;
            ram_en_reg        <= ram_en_next;
            ram_addr_reg      <= ram_addr_next;
            inflight_reg      <= inflight_next;
            inflight_addr_reg <= inflight_addr_next;
            stale_reg         <= stale_next;
        end
    end

    instr_prefetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (rst_i),
        .flush     (branch_i),
        .push      (push),
        .push_data (ram_rdata_i),
        .push_addr (inflight_addr_reg),
        .pop       (pop),
        .valid     (fifo_valid),
        .head_data (instr_rdata_o),
        .head_addr (instr_addr_o),
        .count     (fifo_count)
    );

    assign ram_en_o      = ram_en_reg;
    assign ram_addr_o    = ram_addr_reg;
    assign ram_we_o      = 1'b0;
    assign ram_be_o      = '1;
    assign ram_wdata_o   = '0;
    assign instr_valid_o = (state_reg == ST_RUN) && fifo_valid;

endmodule

// File: tb/tb_instr_ram_prefetch.sv
// Bench for instr_ram_prefetch: a default-depth and a depth-4 instance share stimulus and
// a preloaded RAM; a stream-level model predicts issue/delivery addresses and data.
module tb_instr_ram_prefetch;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        branch;
    logic [14:0] baddr;
    logic        ready;

    logic        en_a, we_a, valid_a;
    logic [14:0] raddr_a, iaddr_a;
    logic [3:0]  be_a;
    logic [31:0] wdata_a, rdata_a, idata_a;

    logic        en_b, we_b, valid_b;
    logic [14:0] raddr_b, iaddr_b;
    logic [3:0]  be_b;
    logic [31:0] wdata_b, rdata_b, idata_b;

    logic [31:0] ram_mem [0:8191];

    int checks = 0;
    int errors = 0;

    instr_ram_prefetch dut (
        .clk(clk), .rst_i(rst), .enable_i(enable), .branch_i(branch), .branch_addr_i(baddr),
        .ram_en_o(en_a), .ram_addr_o(raddr_a), .ram_we_o(we_a), .ram_be_o(be_a),
        .ram_wdata_o(wdata_a), .ram_rdata_i(rdata_a), .instr_valid_o(valid_a),
        .instr_rdata_o(idata_a), .instr_addr_o(iaddr_a), .instr_ready_i(ready)
    );

    instr_ram_prefetch #(.FIFO_DEPTH(4)) dut4 (
        .clk(clk), .rst_i(rst), .enable_i(enable), .branch_i(branch), .branch_addr_i(baddr),
        .ram_en_o(en_b), .ram_addr_o(raddr_b), .ram_we_o(we_b), .ram_be_o(be_b),
        .ram_wdata_o(wdata_b), .ram_rdata_i(rdata_b), .instr_valid_o(valid_b),
        .instr_rdata_o(idata_b), .instr_addr_o(iaddr_b), .instr_ready_i(ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (en_a) rdata_a <= ram_mem[raddr_a[14:2]];
        if (en_b) rdata_b <= ram_mem[raddr_b[14:2]];
    end

    logic        en_w    [2];
    logic        valid_w [2];
    logic [14:0] raddr_w [2];
    logic [14:0] iaddr_w [2];
    logic [31:0] idata_w [2];
    assign en_w[0] = en_a;       assign en_w[1] = en_b;
    assign valid_w[0] = valid_a; assign valid_w[1] = valid_b;
    assign raddr_w[0] = raddr_a; assign raddr_w[1] = raddr_b;
    assign iaddr_w[0] = iaddr_a; assign iaddr_w[1] = iaddr_b;
    assign idata_w[0] = idata_a; assign idata_w[1] = idata_b;

    // Reference: after a branch both the issued and delivered addresses run
    // sequentially from the branch word; reads never exceed buffer capacity.
    bit          m_idle = 1'b1;
    logic [14:0] m_issue [2];
    logic [14:0] m_deliv [2];
    int          m_issued [2];
    int          m_popped [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            int dep;
            dep = (k == 0) ? 2 : 4;
            if (m_idle) begin
                chk("idle_ram_en", 32'(en_w[k]), 32'd0);
                chk("idle_valid", 32'(valid_w[k]), 32'd0);
            end else begin
                if (en_w[k]) begin
                    chk("issue_addr", 32'(raddr_w[k]), 32'(m_issue[k]));
                    m_issue[k] = m_issue[k] + 15'd4;
                    m_issued[k]++;
                end
                if (valid_w[k]) begin
                    chk("head_addr", 32'(iaddr_w[k]), 32'(m_deliv[k]));
                    chk("head_data", idata_w[k], ram_mem[m_deliv[k][14:2]]);
                    if (ready && !branch && !rst) begin
                        m_deliv[k] = m_deliv[k] + 15'd4;
                        m_popped[k]++;
                    end
                end
                chk("outstanding_le_depth", 32'((m_issued[k] - m_popped[k]) <= dep), 32'd1);
            end
        end
        if (rst) begin
            m_idle = 1'b1;
        end else if (branch) begin
            m_idle = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_issue[k]  = {baddr[14:2], 2'b00};
                m_deliv[k]  = {baddr[14:2], 2'b00};
                m_issued[k] = 0;
                m_popped[k] = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_head(input logic [14:0] exp_addr);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (valid_w[0]) begin
                chk("seq_head_addr", 32'(iaddr_w[0]), 32'(exp_addr));
                found = 1'b1;
            end
            tick();
        end
        if (!found) chk("seq_head_timeout", 32'(found), 32'd1);
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ram_en", 32'(en_w[k]), 32'd0);
            chk("rst_ram_addr", 32'(raddr_w[k]), 32'd0);
            chk("rst_valid", 32'(valid_w[k]), 32'd0);
            chk("rst_instr_addr", 32'(iaddr_w[k]), 32'd0);
            chk("rst_instr_rdata", idata_w[k], 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_en_a, n_en_b;
        bit          found;
        logic [14:0] saved_a, saved_b;

        for (int i = 0; i < 8192; i++) ram_mem[i] = $urandom;
        rst = 1'b1; enable = 1'b1; branch = 1'b0; baddr = '0; ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs();
        chk("ram_we_const", 32'(we_a), 32'd0);
        chk("ram_be_const", 32'(be_a), 32'hF);
        chk("ram_wdata_const", wdata_a, 32'd0);
        tick();
        tick();

        // Branch to 0x0100 with consumer ready: latency and throughput
        baddr = 15'h0100; branch = 1'b1;
        tick();
        branch = 1'b0;
        chk("t1_ram_en_d2", 32'(en_a), 32'd1);
        chk("t1_ram_en_d4", 32'(en_b), 32'd1);
        chk("t1_ram_addr", 32'(raddr_a), 32'h0100);
        tick();
        chk("t2_valid_d2", 32'(valid_a), 32'd0);
        chk("t2_valid_d4", 32'(valid_b), 32'd0);
        tick();
        chk("t3_valid_d2", 32'(valid_a), 32'd1);
        chk("t3_addr_d2", 32'(iaddr_a), 32'h0100);
        chk("t3_valid_d4", 32'(valid_b), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("sustain_valid_d4", 32'(valid_b), 32'd1);
            tick();
        end

        // Consumer stalled after branch to 0x0000: reads limited to buffer depth
        ready = 1'b0; baddr = 15'h0000; branch = 1'b1;
        tick();
        branch = 1'b0;
        n_en_a = 0; n_en_b = 0;
        for (int i = 0; i < 8; i++) begin
            if (en_a) n_en_a++;
            if (en_b) n_en_b++;
            tick();
        end
        chk("stall_reads_d2", 32'(n_en_a), 32'd2);
        chk("stall_reads_d4", 32'(n_en_b), 32'd4);
        chk("stall_valid", 32'(valid_a), 32'd1);
        chk("stall_addr", 32'(iaddr_a), 32'h0000);
        chk("stall_en_off", 32'(en_a), 32'd0);

        // Address wrap at the top of the RAM
        ready = 1'b1; baddr = 15'h7FF8; branch = 1'b1;
        tick();
        branch = 1'b0;
        wait_head(15'h7FF8);
        wait_head(15'h7FFC);
        wait_head(15'h0000);

        // Branch while the read of 0x0040 is in flight, with a coinciding pop
        baddr = 15'h0000; branch = 1'b1;
        tick();
        branch = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (en_a && raddr_a == 15'h0040) found = 1'b1;
            else tick();
        end
        chk("find_read_0040", 32'(found), 32'd1);
        baddr = 15'h0200; branch = 1'b1;
        tick();
        branch = 1'b0;
        wait_head(15'h0200);

        // enable_i dropped mid-stream, then restored
        baddr = 15'h0300; branch = 1'b1;
        tick();
        branch = 1'b0;
        repeat (4) tick();
        enable = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("disabled_en_d2", 32'(en_a), 32'd0);
            chk("disabled_en_d4", 32'(en_b), 32'd0);
            tick();
        end
        saved_a = m_issue[0];
        saved_b = m_issue[1];
        enable = 1'b1;
        tick();
        chk("resume_en", 32'(en_a), 32'd1);
        chk("resume_addr_d2", 32'(raddr_a), 32'(saved_a));
        chk("resume_addr_d4", 32'(raddr_b), 32'(saved_b));
        repeat (3) tick();

        // One-cycle reset during RUN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs();
        repeat (4) tick();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 9) < 8);
            ready  = ($urandom_range(0, 9) < 7);
            branch = ($urandom_range(0, 19) == 0);
            rst    = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) baddr = 15'h7FF0 + 15'($urandom_range(0, 15));
            else baddr = 15'($urandom);
            tick();
        end
        rst = 1'b0; branch = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
